// File: rtl/mul_tree_feeder_bf16_pkg.sv
// Shared definitions for the bf16 multiplier-tree operand feeder.
// The mode encodings are common with the tree itself.
package mul_tree_feeder_bf16_pkg;

    typedef enum logic [1:0] {
        TWO_IN   = 2'd0,
        THREE_IN = 2'd1,
        FOUR_IN  = 2'd2,
        SIX_IN   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam logic [15:0] BF16_ONE = 16'h3F80;
    localparam int          SLOTS    = 8;

endpackage

// File: rtl/mul_tree_feeder_bf16_if.sv
// Serial bf16 operand stream from the node-value scheduler into the feeder.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
// in_data/in_last/in_mode are held stable by the master while in_valid is high.
interface mul_tree_feeder_bf16_if;

    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_mode;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output in_mode,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  in_mode,
        output in_ready
    );

endinterface

// File: rtl/mul_tree_feeder_bf16.sv
// Packs up to eight serial bf16 operands into one 128-bit bundle for the tree,
// tracking bundles in flight so the mode only changes on an empty pipeline.
module mul_tree_feeder_bf16
    import mul_tree_feeder_bf16_pkg::*;
#(
    parameter int          MAX_INFLIGHT = 8,
    parameter logic [15:0] PAD          = BF16_ONE
) (
    input  logic                         clk,
    input  logic                         rst,
    mul_tree_feeder_bf16_if.slave        sif,
    output logic [16*SLOTS-1:0]          mul_ins,
    output logic                         mul_stb,
    output mode_e                        mode,
    input  logic [3:0]                   done_stbs,
    output logic [3:0]                   inflight,
    output logic [15:0]                  bundles_issued,
    output logic                         err_underflow,
    output state_e                       state_dbg
);

    state_e     state;
    logic [2:0] slot_cnt;
    logic       done_any;
    logic       at_max;
    logic       drain_hold;
    logic       accept;
    logic       closing;

    assign done_any  = |done_stbs;
    assign at_max    = (inflight == 4'(MAX_INFLIGHT));
    // A mode change on a bundle's first word waits until the tree has drained.
    assign drain_hold = (state == IDLE) && sif.in_valid &&
                        (mode_e'(sif.in_mode) != mode) && (inflight != 4'd0);
    assign sif.in_ready = rst && (state != ISSUE) && !at_max && !drain_hold;
    assign accept    = sif.in_valid && sif.in_ready;
    assign closing   = sif.in_last || (slot_cnt == 3'(SLOTS - 1));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            slot_cnt       <= 3'd0;
            mul_ins        <= '0;
            mul_stb        <= 1'b0;
            mode           <= TWO_IN;
            inflight       <= 4'd0;
            bundles_issued <= 16'd0;
            err_underflow  <= 1'b0;
        end else begin
            // An issue and a completion in the same cycle cancel out.
            if (mul_stb && !done_any) begin
                inflight <= inflight + 4'd1;
            end else if (!mul_stb && done_any) begin
                if (inflight == 4'd0) begin
                    err_underflow <= 1'b1;
                end else begin
                    inflight <= inflight - 4'd1;
                end
            end

            if (mul_stb) begin
                bundles_issued <= bundles_issued + 16'd1;
            end

            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        if (state == IDLE) begin
                            mode <= mode_e'(sif.in_mode);
                        end
                        // Slots past a closing word are padded on the same edge.
                        for (int k = 0; k < SLOTS; k++) begin
                            if (3'(k) == slot_cnt) begin
                                mul_ins[16*k +: 16] <= sif.in_data;
                            end else if (closing && (3'(k) > slot_cnt)) begin
                                mul_ins[16*k +: 16] <= PAD;
                            end
                        end
                        if (closing) begin
                            state    <= ISSUE;
                            mul_stb  <= 1'b1;
                            slot_cnt <= 3'd0;
                        end else begin
                            state    <= FILL;
                            slot_cnt <= slot_cnt + 3'd1;
                        end
                    end
                end
                ISSUE: begin
                    state   <= IDLE;
                    mul_stb <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mul_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_tree_feeder_bf16.sv
// Bench for mul_tree_feeder_bf16: directed scenarios plus random bundles,
// checked against a word-list/bundle reference model with an expected queue.
module tb_mul_tree_feeder_bf16;
    import mul_tree_feeder_bf16_pkg::*;

    localparam int          MAXI = 2;
    localparam logic [15:0] PADV = 16'h3F80;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   done_stbs = 4'd0;
    logic [127:0] mul_ins;
    logic         mul_stb;
    logic [1:0]   mode_o;
    logic [3:0]   inflight;
    logic [15:0]  bundles_issued;
    logic         err_underflow;
    logic [1:0]   state_o;

    mul_tree_feeder_bf16_if sif();

    mul_tree_feeder_bf16 #(.MAX_INFLIGHT(MAXI), .PAD(PADV)) dut (
        .clk            (clk),
        .rst            (rst),
        .sif            (sif.slave),
        .mul_ins        (mul_ins),
        .mul_stb        (mul_stb),
        .mode           (mode_o),
        .done_stbs      (done_stbs),
        .inflight       (inflight),
        .bundles_issued (bundles_issued),
        .err_underflow  (err_underflow),
        .state_dbg      (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: words of the open bundle, completed bundles awaiting issue.
    int           m_cnt;
    logic [15:0]  m_words [8];
    logic [1:0]   m_mode;
    logic [3:0]   m_inflight;
    logic [15:0]  m_issued;
    logic         m_err;
    logic         m_issue;
    logic [127:0] exp_q [$];
    logic [1:0]   mode_q [$];

    int n_chk = 0;
    int n_pass = 0;

    function automatic void model_reset();
        m_cnt      = 0;
        m_mode     = 2'd0;
        m_inflight = 4'd0;
        m_issued   = 16'd0;
        m_err      = 1'b0;
        m_issue    = 1'b0;
        exp_q.delete();
        mode_q.delete();
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive, check pre-edge outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [15:0] d, input logic l,
                         input logic [1:0] m, input logic [3:0] dn, output logic acc);
        logic         exp_ready;
        logic [1:0]   exp_state;
        logic [1:0]   bm;
        logic [127:0] b;
        sif.in_valid = v;
        sif.in_data  = d;
        sif.in_last  = l;
        sif.in_mode  = m;
        done_stbs    = dn;
        #3;
        exp_ready = rst && !m_issue && (m_inflight != 4'(MAXI)) &&
                    !(m_cnt == 0 && v && (m != m_mode) && (m_inflight != 4'd0));
        exp_state = m_issue ? ISSUE : ((m_cnt == 0) ? IDLE : FILL);
        check("in_ready", 128'(sif.in_ready), 128'(exp_ready));
        check("mul_stb", 128'(mul_stb), 128'(m_issue));
        check("inflight", 128'(inflight), 128'(m_inflight));
        check("bundles_issued", 128'(bundles_issued), 128'(m_issued));
        check("err_underflow", 128'(err_underflow), 128'(m_err));
        check("mode", 128'(mode_o), 128'(m_mode));
        check("state", 128'(state_o), 128'(exp_state));
        if (m_issue) begin
            b  = exp_q.pop_front();
            bm = mode_q.pop_front();
            check("mul_ins", mul_ins, b);
            check("issue_mode", 128'(mode_o), 128'(bm));
        end
        acc = v && exp_ready;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_issue && dn == 4'd0) begin
                m_inflight++;
            end else if (!m_issue && dn != 4'd0) begin
                if (m_inflight == 4'd0) m_err = 1'b1;
                else m_inflight--;
            end
            if (m_issue) m_issued++;
            m_issue = 1'b0;
            if (acc) begin
                if (m_cnt == 0) m_mode = m;
                m_words[m_cnt] = d;
                m_cnt++;
                if (l || m_cnt == 8) begin
                    for (int k = 0; k < 8; k++) b[16*k +: 16] = (k < m_cnt) ? m_words[k] : PADV;
                    exp_q.push_back(b);
                    mode_q.push_back(m_mode);
                    m_cnt   = 0;
                    m_issue = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] dn);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 1'b0, 2'd0, dn, acc);
    endtask

    // Holds a word valid until taken; random completions only while bundles are outstanding.
    task automatic send_word(input logic [15:0] d, input logic l, input logic [1:0] m, input int done_pct);
        logic       acc;
        logic [3:0] dn;
        for (int i = 0; i < 200; i++) begin
            dn = (m_inflight != 4'd0 && int'($urandom_range(99)) < done_pct) ? 4'($urandom_range(15, 1)) : 4'd0;
            cycle(1'b1, d, l, m, dn, acc);
            if (acc) return;
        end
        n_chk++;
        $error("FAIL send_word_timeout: word %0h not accepted, expected acceptance within 200 cycles", d);
    endtask

    initial begin
        logic [127:0] exp_b;
        logic         acc;
        int           len;
        logic [1:0]   bmode;

        sif.in_valid = 1'b0;
        sif.in_data  = 16'd0;
        sif.in_last  = 1'b0;
        sif.in_mode  = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        idle(2, 4'd0);
        check("reset_mul_ins", mul_ins, 128'd0);
        check("reset_in_ready", 128'(sif.in_ready), 128'd0);
        rst = 1'b1;

        // Full bundle in mode 0.
        for (int k = 0; k < 8; k++) send_word(16'h3F80 + 16'(16'h20 * k), 1'b0, 2'd0, 0);
        idle(1, 4'd0);
        for (int k = 0; k < 8; k++) exp_b[16*k +: 16] = 16'h3F80 + 16'(16'h20 * k);
        check("t1_mul_ins_held", mul_ins, exp_b);
        check("t1_inflight", 128'(inflight), 128'd1);

        // Truncated bundle: slots 3..7 padded.
        send_word(16'h4000, 1'b0, 2'd0, 0);
        send_word(16'h4040, 1'b0, 2'd0, 0);
        send_word(16'h4080, 1'b1, 2'd0, 0);
        idle(1, 4'd0);
        check("t2_mul_ins", mul_ins, {{5{PADV}}, 16'h4080, 16'h4040, 16'h4000});
        check("t2_bundles", 128'(bundles_issued), 128'd2);

        // Mode change with two bundles in flight: held until both complete.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h4200, 1'b0, 2'd3, 4'd0, acc);
        cycle(1'b1, 16'h4200, 1'b0, 2'd3, 4'b0001, acc);
        cycle(1'b1, 16'h4200, 1'b0, 2'd3, 4'b0010, acc);
        check("t3_drain_released", 128'(sif.in_ready), 128'd1);
        send_word(16'h4200, 1'b0, 2'd3, 0);
        check("t3_mode_on_accept", 128'(mode_o), 128'd3);
        for (int k = 1; k < 8; k++) send_word(16'h4200 + 16'(k), 1'b0, 2'd0, 0);
        idle(1, 4'd0);
        check("t3_mode_kept", 128'(mode_o), 128'd3);

        // Single-word bundle, then stall at MAX_INFLIGHT until one completion.
        send_word(16'h4300, 1'b1, 2'd3, 0);
        idle(1, 4'd0);
        check("t4_last_on_word0", mul_ins, {{7{PADV}}, 16'h4300});
        check("t4_at_max", 128'(inflight), 128'd2);
        for (int i = 0; i < 2; i++) cycle(1'b1, 16'h4310, 1'b1, 2'd3, 4'd0, acc);
        cycle(1'b1, 16'h4310, 1'b1, 2'd3, 4'b0011, acc);
        check("t4_resume_ready", 128'(sif.in_ready), 128'd1);
        send_word(16'h4310, 1'b1, 2'd3, 0);
        idle(1, 4'd0);

        // Completion coinciding with the issue strobe leaves inflight unchanged.
        idle(1, 4'b0001);
        send_word(16'h4400, 1'b1, 2'd3, 0);
        idle(1, 4'b1000);
        check("t5_same_cycle", 128'(inflight), 128'd1);
        idle(1, 4'b0100);

        // Random bundles of random length and mode.
        for (int n = 0; n < 40; n++) begin
            len   = $urandom_range(8, 1);
            bmode = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : m_mode;
            for (int k = 0; k < len; k++) begin
                send_word(16'($urandom), (k == len - 1) && (len < 8 || $urandom_range(1) == 1), bmode, 30);
            end
            idle($urandom_range(2), 4'd0);
        end

        // Reset mid-bundle, then a clean bundle.
        idle(2, 4'd0);
        for (int k = 0; k < 5; k++) send_word(16'h4500 + 16'(k), 1'b0, m_mode, 50);
        rst = 1'b0;
        idle(2, 4'd0);
        check("rst_mul_ins", mul_ins, 128'd0);
        check("rst_inflight", 128'(inflight), 128'd0);
        check("rst_bundles", 128'(bundles_issued), 128'd0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) send_word(16'h5000 + 16'(k), 1'b0, 2'd0, 0);
        idle(1, 4'd0);
        for (int k = 0; k < 8; k++) exp_b[16*k +: 16] = 16'h5000 + 16'(k);
        check("rst_clean_bundle", mul_ins, exp_b);

        // Completion with nothing outstanding sets the sticky error.
        idle(1, 4'b0100);
        idle(1, 4'b0001);
        idle(3, 4'd0);
        check("underflow_sticky", 128'(err_underflow), 128'd1);
        check("underflow_inflight", 128'(inflight), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
